// File: rtl/poker_types.sv
// Shared poker card types, font character codes and glyph lookup helpers.
// Used by card_glyph_renderer and other text overlay blocks.
package poker_types;

    typedef logic [3:0] rank_t;

    typedef enum logic [1:0] {
        SUIT_SPADES   = 2'd0,
        SUIT_DIAMONDS = 2'd1,
        SUIT_CLUBS    = 2'd2,
        SUIT_HEARTS   = 2'd3
    } suit_t;

    typedef struct packed {
        rank_t rank;
        suit_t suit;
    } card_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] fx;
        logic       red;
        logic       blank;
        logic       hl;
    } glyph_pipe_t;

    localparam rank_t RANK_ACE  = 4'd0;
    localparam rank_t RANK_TEN  = 4'd9;
    localparam rank_t RANK_JACK = 4'd10;
    localparam rank_t RANK_KING = 4'd12;

    localparam logic [6:0] FONT_CHAR_NONE     = 7'd0;
    localparam logic [6:0] FONT_CHAR_HEARTS   = 7'd3;
    localparam logic [6:0] FONT_CHAR_DIAMONDS = 7'd4;
    localparam logic [6:0] FONT_CHAR_CLUBS    = 7'd5;
    localparam logic [6:0] FONT_CHAR_SPADES   = 7'd6;
    localparam logic [6:0] FONT_CHAR_ZERO     = 7'd48;
    localparam logic [6:0] FONT_CHAR_ONE      = 7'd49;
    localparam logic [6:0] FONT_CHAR_A        = 7'd65;
    localparam logic [6:0] FONT_CHAR_J        = 7'd74;
    localparam logic [6:0] FONT_CHAR_K        = 7'd75;
    localparam logic [6:0] FONT_CHAR_Q        = 7'd81;

    // Ranks 2..9 map onto consecutive digits; Ten shows as "1" then "0".
    function automatic logic [6:0] rank_char(input rank_t r);
        logic [6:0] c;
        c = FONT_CHAR_NONE;
        if (r == RANK_ACE)
            c = FONT_CHAR_A;
        else if (r < RANK_TEN)
            c = FONT_CHAR_ONE + 7'(r);
        else if (r == RANK_TEN)
            c = FONT_CHAR_ONE;
        else if (r == RANK_JACK)
            c = FONT_CHAR_J;
        else if (r == RANK_JACK + 4'd1)
            c = FONT_CHAR_Q;
        else if (r == RANK_KING)
            c = FONT_CHAR_K;
        return c;
    endfunction

    function automatic logic [6:0] suit_char(input suit_t s);
        logic [6:0] c;
        case (s)
            SUIT_SPADES:   c = FONT_CHAR_SPADES;
            SUIT_DIAMONDS: c = FONT_CHAR_DIAMONDS;
            SUIT_CLUBS:    c = FONT_CHAR_CLUBS;
            default:       c = FONT_CHAR_HEARTS;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/card_glyph_addr.sv
// Combinational cell-local coordinate to font ROM address mapping.
// Left column holds rank (top) and suit (bottom); right column only Ten's "0".
module card_glyph_addr
    import poker_types::*;
(
    input  card_t       card_i,
    input  logic [3:0]  fx_i,
    input  logic [4:0]  fy_i,
    output logic [10:0] addr_o,
    output logic        blank_o,
    output logic        red_o
);

    logic [6:0] ch;

    // Select the character for this quadrant of the cell
    always_comb begin
        ch = FONT_CHAR_NONE;
        if (card_i.rank <= RANK_KING) begin
            if (!fy_i[4] && !fx_i[3])
                ch = rank_char(card_i.rank);
            else if (!fy_i[4] && card_i.rank == RANK_TEN)
                ch = FONT_CHAR_ZERO;
            else if (fy_i[4] && !fx_i[3])
                ch = suit_char(card_i.suit);
        end
        blank_o = (ch == FONT_CHAR_NONE);
        addr_o  = blank_o ? 11'd0 : {ch, fy_i[3:0]};
        red_o   = card_i.suit[0];
    end

endmodule

// File: rtl/card_glyph_renderer.sv
// Pipelined multi-slot card glyph overlay; latency ROM_LAT+2 from DrawX/DrawY.
// Optional macro CARD_BLINK_EN enables frame-based blinking of highlighted slots.
module card_glyph_renderer
    import poker_types::*;
#(
    parameter int NUM_SLOTS    = 9,
    parameter int SCALE_LOG2   = 0,
    parameter int ROM_LAT      = 1,
    parameter int BLINK_FRAMES = 30,
    localparam int IW          = $clog2(NUM_SLOTS)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic          frame_start,
    input  logic          slot_we,
    input  logic [IW-1:0] slot_idx,
    input  logic [9:0]    slot_x,
    input  logic [9:0]    slot_y,
    input  card_t         slot_card,
    input  logic          slot_visible,
    input  logic          slot_hl,
    input  logic [7:0]    font_data,
    output logic [10:0]   font_address,
    output logic          text_on,
    output logic          red_font,
    output logic          black_font
);

    localparam logic [10:0] CELL_W = 11'(16 << SCALE_LOG2);
    localparam logic [10:0] CELL_H = 11'(32 << SCALE_LOG2);

    logic [9:0]  x_q   [NUM_SLOTS];
    logic [9:0]  y_q   [NUM_SLOTS];
    card_t       card_q[NUM_SLOTS];
    logic        vis_q [NUM_SLOTS];
    logic        hl_q  [NUM_SLOTS];

    logic        hit;
    logic [10:0] dx, dy, hit_dx, hit_dy;
    card_t       hit_card;
    logic        hit_hl;
    logic [10:0] g_addr;
    logic        g_blank, g_red;

    glyph_pipe_t s1_q;
    glyph_pipe_t dl_q[ROM_LAT];
    glyph_pipe_t tail;
    logic        blink_phase;
    logic        pix_on;

    // Slot geometry and card; only the flags need a defined reset value
    always_ff @(posedge Clk) begin
        if (slot_we && int'(slot_idx) < NUM_SLOTS) begin
            x_q[slot_idx]    <= slot_x;
            y_q[slot_idx]    <= slot_y;
            card_q[slot_idx] <= slot_card;
        end
    end

    // Slot visible/highlight flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                vis_q[i] <= 1'b0;
                hl_q[i]  <= 1'b0;
            end
        end else if (slot_we && int'(slot_idx) < NUM_SLOTS) begin
            vis_q[slot_idx] <= slot_visible;
            hl_q[slot_idx]  <= slot_hl;
        end
    end

    // Hit test; scanning downward lets the lowest index win on overlap
    always_comb begin
        hit      = 1'b0;
        dx       = '0;
        dy       = '0;
        hit_dx   = '0;
        hit_dy   = '0;
        hit_card = '0;
        hit_hl   = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            dx = {1'b0, DrawX} - {1'b0, x_q[i]};
            dy = {1'b0, DrawY} - {1'b0, y_q[i]};
            if (vis_q[i] && dx < CELL_W && dy < CELL_H) begin
                hit      = 1'b1;
                hit_dx   = dx;
                hit_dy   = dy;
                hit_card = card_q[i];
                hit_hl   = hl_q[i];
            end
        end
    end

    card_glyph_addr u_addr (
        .card_i  (hit_card),
        .fx_i    (4'(hit_dx >> SCALE_LOG2)),
        .fy_i    (5'(hit_dy >> SCALE_LOG2)),
        .addr_o  (g_addr),
        .blank_o (g_blank),
        .red_o   (g_red)
    );

    // Stage 1: ROM address plus per-pixel attributes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            font_address <= '0;
            s1_q         <= '0;
        end else begin
            font_address <= hit ? g_addr : 11'd0;
            s1_q.valid   <= hit;
            s1_q.fx      <= 3'(hit_dx >> SCALE_LOG2);
            s1_q.red     <= g_red;
            s1_q.blank   <= g_blank;
            s1_q.hl      <= hit_hl;
        end
    end

    // Delay line matching the font ROM read latency
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < ROM_LAT; k++)
                dl_q[k] <= '0;
        end else begin
            dl_q[0] <= s1_q;
            for (int k = 1; k < ROM_LAT; k++)
                dl_q[k] <= dl_q[k-1];
        end
    end

    assign tail   = dl_q[ROM_LAT-1];
    assign pix_on = tail.valid & ~tail.blank & font_data[~tail.fx]
                  & ~(tail.hl & blink_phase);

    // Output stage
    always_ff @(posedge Clk) begin
        if (Reset) begin
            text_on    <= 1'b0;
            red_font   <= 1'b0;
            black_font <= 1'b0;
        end else begin
            text_on    <= pix_on;
            red_font   <= pix_on & tail.red;
            black_font <= pix_on & ~tail.red;
        end
    end

`ifdef CARD_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    logic [BW-1:0] frame_cnt_q;
    logic          blink_phase_q;

    // Frame counter toggles the blink phase every BLINK_FRAMES frames
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign blink_phase = blink_phase_q;
`else
    assign blink_phase = frame_start & 1'b0;
`endif

endmodule

// File: tb/tb_card_glyph_renderer.sv
// Directed bench for card_glyph_renderer: default build plus a scaled,
// ROM_LAT=2 instance sharing the same slot-table stimulus.
module tb_card_glyph_renderer;
    import poker_types::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        frame_start;
    logic        slot_we;
    logic [3:0]  slot_idx;
    logic [9:0]  slot_x, slot_y;
    card_t       slot_card;
    logic        slot_visible, slot_hl;

    logic [7:0]  fd_a, fd_b, rom_a_q, rom_b_q1, rom_b_q2;
    logic [10:0] addr_a, addr_b;
    logic        text_a, red_a, black_a;
    logic        text_b, red_b, black_b;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_on [5];

    always #5 Clk = ~Clk;

    card_glyph_renderer #(.BLINK_FRAMES(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .slot_we(slot_we),
        .slot_idx(slot_idx), .slot_x(slot_x), .slot_y(slot_y),
        .slot_card(slot_card), .slot_visible(slot_visible),
        .slot_hl(slot_hl), .font_data(fd_a),
        .font_address(addr_a), .text_on(text_a),
        .red_font(red_a), .black_font(black_a)
    );

    card_glyph_renderer #(
        .SCALE_LOG2(1), .ROM_LAT(2), .BLINK_FRAMES(2)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .slot_we(slot_we),
        .slot_idx(slot_idx), .slot_x(slot_x), .slot_y(slot_y),
        .slot_card(slot_card), .slot_visible(slot_visible),
        .slot_hl(slot_hl), .font_data(fd_b),
        .font_address(addr_b), .text_on(text_b),
        .red_font(red_b), .black_font(black_b)
    );

    function automatic logic [7:0] rom(input logic [10:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    function automatic logic [31:0] ebit(input int a, input int fx);
        logic [7:0] r;
        r = rom(11'(a));
        return {31'd0, r[7 - fx]};
    endfunction

    always @(posedge Clk) begin
        rom_a_q  <= rom(addr_a);
        rom_b_q1 <= rom(addr_b);
        rom_b_q2 <= rom_b_q1;
    end
    assign fd_a = rom_a_q;
    assign fd_b = rom_b_q2;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_slot(input int idx, input int x, input int y,
                              input int rank, input int suit,
                              input int vis, input int hl);
        slot_we        = 1'b1;
        slot_idx       = 4'(idx);
        slot_x         = 10'(x);
        slot_y         = 10'(y);
        slot_card.rank = 4'(rank);
        slot_card.suit = suit_t'(2'(suit));
        slot_visible   = 1'(vis);
        slot_hl        = 1'(hl);
        tick(1);
        slot_we = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(4);
    endtask

    initial begin
        int a;
        Reset = 1'b1;
        frame_start = 1'b0;
        slot_we = 1'b0;
        slot_idx = '0;
        slot_x = '0;
        slot_y = '0;
        slot_card = '0;
        slot_visible = 1'b0;
        slot_hl = 1'b0;
        pix(0, 0);
        tick(3);
        check("rst_addr", 32'(addr_a), 0);
        check("rst_text", 32'(text_a), 0);
        check("rst_red", 32'(red_a), 0);
        check("rst_black", 32'(black_a), 0);
        Reset = 1'b0;
        tick(1);

        write_slot(0, 120, 210, 0, 0, 1, 0);
        for (int x = 120; x < 128; x++) begin
            pix(x, 210);
            tick(4);
            check("t1_addr", 32'(addr_a), 1040);
            check("t1_text", 32'(text_a), ebit(1040, x - 120));
            check("t1_black", 32'(black_a), ebit(1040, x - 120));
            check("t1_red", 32'(red_a), 0);
        end
        pix(128, 210);
        tick(4);
        check("t1_blank_addr", 32'(addr_a), 0);
        check("t1_blank_text", 32'(text_a), 0);
        pix(119, 210);
        tick(4);
        check("t1_left_addr", 32'(addr_a), 0);

        write_slot(1, 200, 100, 9, 3, 1, 0);
        for (int x = 200; x < 216; x++) begin
            a = (x < 208) ? 789 : 773;
            pix(x, 105);
            tick(4);
            check("t2_addr", 32'(addr_a), 32'(a));
            check("t2_red", 32'(red_a), ebit(a, (x - 200) % 8));
            check("t2_black", 32'(black_a), 0);
        end
        pix(200, 118);
        tick(4);
        check("t2_suit_addr", 32'(addr_a), 50);

        write_slot(2, 300, 300, 12, 2, 1, 0);
        write_slot(5, 300, 300, 11, 1, 1, 0);
        pix(300, 300);
        tick(4);
        check("t3_prio_addr", 32'(addr_a), 1200);
        check("t3_prio_black", 32'(black_a), ebit(1200, 0));
        slot_we = 1'b1;
        slot_idx = 4'd2;
        slot_visible = 1'b0;
        tick(1);
        slot_we = 1'b0;
        check("t3_old_entry", 32'(addr_a), 1200);
        tick(1);
        check("t3_new_entry", 32'(addr_a), 1296);
        tick(4);
        check("t3_red", 32'(red_a), ebit(1296, 0));

        write_slot(15, 600, 20, 0, 0, 1, 0);
        pix(600, 20);
        tick(4);
        check("idx_oob_addr", 32'(addr_a), 0);

        pix(121, 211);
        tick(4);
        check("t4_addr0", 32'(addr_b), 1040);
        pix(122, 212);
        tick(4);
        check("t4_addr1", 32'(addr_b), 1041);
        check("t4_text1", 32'(text_b), ebit(1041, 1));
        pix(151, 210);
        tick(4);
        check("t4_rblank", 32'(addr_b), 0);
        pix(152, 210);
        tick(4);
        check("t4_xout", 32'(addr_b), 0);
        pix(120, 273);
        tick(4);
        check("t4_suit", 32'(addr_b), 111);
        check("t4_suit_text", 32'(text_b), ebit(111, 0));
        pix(120, 274);
        tick(4);
        check("t4_yout", 32'(addr_b), 0);
        pix(50, 50);
        tick(5);
        pix(120, 210);
        tick(2);
        check("lat_a_early", 32'(text_a), 0);
        tick(1);
        check("lat_a", 32'(text_a), ebit(1040, 0));
        check("lat_b_early", 32'(text_b), 0);
        tick(1);
        check("lat_b", 32'(text_b), ebit(1040, 0));

        write_slot(3, 1020, 50, 0, 0, 1, 0);
        for (int x = 0; x < 16; x++) begin
            pix(x, 50);
            tick(4);
            check("t5_wrap_addr", 32'(addr_a), 0);
            check("t5_wrap_text", 32'(text_a), 0);
        end
        pix(1020, 50);
        tick(4);
        check("t5_edge_addr", 32'(addr_a), 1040);
        write_slot(4, 400, 400, 14, 0, 1, 0);
        for (int x = 400; x < 416; x++) begin
            pix(x, 400);
            tick(4);
            check("t5_rank14", 32'(text_a), 0);
        end
        pix(400, 420);
        tick(4);
        check("t5_rank14_suit", 32'(text_a), 0);

`ifdef CARD_BLINK_EN
        exp_on = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd1};
`else
        exp_on = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
`endif
        write_slot(0, 120, 210, 0, 0, 1, 1);
        pix(120, 210);
        tick(4);
        check("t6_frame0", 32'(text_a), exp_on[0]);
        for (int f = 1; f <= 4; f++) begin
            frame_pulse();
            check("t6_blink", 32'(text_a), exp_on[f]);
            if (f == 2) begin
                pix(200, 105);
                tick(4);
                check("t6_nonhl", 32'(text_a), ebit(789, 0));
                pix(120, 210);
                tick(4);
                check("t6_blink_hold", 32'(text_a), exp_on[f]);
            end
        end

        Reset = 1'b1;
        tick(1);
        check("t5_rst_text", 32'(text_a), 0);
        check("t5_rst_black", 32'(black_a), 0);
        check("t5_rst_addr", 32'(addr_a), 0);
        check("t5_rst_text_b", 32'(text_b), 0);
        Reset = 1'b0;
        tick(4);
        check("t5_post_rst", 32'(text_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
